// File: rtl/cache_refill_ctrl_pkg.sv
// cache_refill_ctrl_pkg: shared constants and FSM encoding for the cache miss refill path.
package cache_refill_ctrl_pkg;
    localparam int LINE_WORDS = 16;
    localparam int INDEX_W = 6;
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam logic [3:0] BURST_LEN = 4'd15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WB_LOAD,
        S_WB_AREQ,
        S_WB_DATA,
        S_WB_RESP,
        S_RD_AREQ,
        S_RD_DATA,
        S_REFRESH,
        S_SETTLE
    } state_t;
endpackage

// File: rtl/cache_refill_ctrl_line_buf.sv
// cache_line_buf: one-line register buffer holding the victim between array read-out and AXI write.
module cache_line_buf
    import cache_refill_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [WORD_W-1:0] wptr,
    input  logic [31:0]       wdata,
    input  logic [WORD_W-1:0] rptr,
    output logic [31:0]       rdata
);
    logic [31:0] mem [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss-side refill FSM; buffers and writes back a dirty victim,
// then fetches the new line over AXI into the victim way and pulses refresh.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               miss,
    input  logic               write_back,
    input  logic               lru,
    input  logic [31:0]        axi_raddr,
    input  logic [31:0]        axi_waddr,
    output logic               refresh,
    output logic               busy,
    output logic               rd_req,
    output logic [31:0]        rd_addr,
    output logic [3:0]         rd_len,
    input  logic               rd_ready,
    input  logic               rd_valid,
    input  logic [31:0]        rd_data,
    output logic               wr_req,
    output logic [31:0]        wr_addr,
    output logic [3:0]         wr_len,
    input  logic               wr_ready,
    output logic               wr_valid,
    output logic [31:0]        wr_data,
    output logic               wr_last,
    input  logic               wr_dready,
    input  logic               wr_bresp,
    output logic               dram_rway,
    output logic [INDEX_W-1:0] dram_rindex,
    output logic [WORD_W-1:0]  dram_rword,
    input  logic [31:0]        dram_rdata,
    output logic [1:0]         dram_we,
    output logic [INDEX_W-1:0] dram_windex,
    output logic [WORD_W-1:0]  dram_wword,
    output logic [31:0]        dram_wdata
);
    state_t state, next;
    logic               way;
    logic [INDEX_W-1:0] index;
    logic [31:0]        raddr, waddr;
    logic [WORD_W:0]    ld_cnt;
    logic [WORD_W-1:0]  wcnt, rcnt;
    logic               load, beat, buf_we;
    logic [31:0]        buf_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            way    <= 1'b0;
            index  <= '0;
            raddr  <= '0;
            waddr  <= '0;
            ld_cnt <= '0;
            wcnt   <= '0;
            rcnt   <= '0;
        end else begin
            state <= next;
            if (state == S_IDLE && miss) begin
                way    <= lru;
                index  <= axi_raddr[6 +: INDEX_W];
                raddr  <= axi_raddr;
                waddr  <= axi_waddr;
                ld_cnt <= '0;
                wcnt   <= '0;
                rcnt   <= '0;
            end
            if (state == S_WB_LOAD) ld_cnt <= ld_cnt + 1'b1;
            if (wr_valid && wr_dready) wcnt <= wcnt + 1'b1;
            if (beat) rcnt <= rcnt + 1'b1;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:    if (miss) next = write_back ? S_WB_LOAD : S_RD_AREQ;
            S_WB_LOAD: if (ld_cnt[WORD_W]) next = S_WB_AREQ;
            S_WB_AREQ: if (wr_ready) next = S_WB_DATA;
            S_WB_DATA: if (wr_dready && wcnt == BURST_LEN) next = S_WB_RESP;
            S_WB_RESP: if (wr_bresp) next = S_RD_AREQ;
            S_RD_AREQ: if (rd_ready) next = S_RD_DATA;
            S_RD_DATA: if (rd_valid && rcnt == BURST_LEN) next = S_REFRESH;
            S_REFRESH: next = S_SETTLE;
            S_SETTLE:  next = S_IDLE;
            default:   next = S_IDLE;
        endcase
    end

    // Array reads are issued for ld_cnt 0..15; each result lands one cycle later.
    assign load   = state == S_WB_LOAD && !ld_cnt[WORD_W];
    assign buf_we = state == S_WB_LOAD && ld_cnt != '0;
    assign beat   = state == S_RD_DATA && rd_valid;

    cache_line_buf u_buf (
        .clk   (clk),
        .we    (buf_we),
        .wptr  (ld_cnt[WORD_W-1:0] - 1'b1),
        .wdata (dram_rdata),
        .rptr  (wcnt),
        .rdata (buf_rdata)
    );

    assign busy        = state != S_IDLE;
    assign refresh     = state == S_REFRESH;
    assign rd_req      = state == S_RD_AREQ;
    assign rd_addr     = raddr;
    assign rd_len      = busy ? BURST_LEN : 4'd0;
    assign wr_req      = state == S_WB_AREQ;
    assign wr_addr     = waddr;
    assign wr_len      = busy ? BURST_LEN : 4'd0;
    assign wr_valid    = state == S_WB_DATA;
    assign wr_data     = wr_valid ? buf_rdata : 32'd0;
    assign wr_last     = wr_valid && wcnt == BURST_LEN;
    assign dram_rway   = load & way;
    assign dram_rindex = load ? index : '0;
    assign dram_rword  = load ? ld_cnt[WORD_W-1:0] : '0;
    assign dram_we     = beat ? (way ? 2'b10 : 2'b01) : 2'b00;
    assign dram_windex = beat ? index : '0;
    assign dram_wword  = beat ? rcnt : '0;
    assign dram_wdata  = beat ? rd_data : 32'd0;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized AXI/array responders plus a transaction-level scoreboard
// that checks writeback data, refill placement, handshake ordering and refresh timing.
module tb_cache_refill_ctrl;
    logic        clk = 1'b0;
    logic        rst, miss, write_back, lru;
    logic [31:0] axi_raddr, axi_waddr;
    logic        refresh, busy, rd_req, rd_ready, rd_valid;
    logic [31:0] rd_addr, rd_data, wr_addr, wr_data, dram_rdata, dram_wdata;
    logic [3:0]  rd_len, wr_len, dram_rword, dram_wword;
    logic        wr_req, wr_ready, wr_valid, wr_last, wr_dready, wr_bresp, dram_rway;
    logic [5:0]  dram_rindex, dram_windex;
    logic [1:0]  dram_we;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst), .miss(miss), .write_back(write_back), .lru(lru),
        .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .refresh(refresh), .busy(busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_len(wr_len), .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_last(wr_last), .wr_dready(wr_dready), .wr_bresp(wr_bresp),
        .dram_rway(dram_rway), .dram_rindex(dram_rindex), .dram_rword(dram_rword),
        .dram_rdata(dram_rdata), .dram_we(dram_we), .dram_windex(dram_windex),
        .dram_wword(dram_wword), .dram_wdata(dram_wdata)
    );

    always #5 clk = ~clk;

    // Transactions requested by the sequencer, consumed in order by the scoreboard.
    bit          txn_dirty [64];
    bit          txn_way   [64];
    logic [31:0] txn_raddr [64];
    logic [31:0] txn_waddr [64];
    logic [5:0]  txn_idx   [64];
    logic [31:0] txn_data  [64][16];
    int          n_pushed = 0;
    int cfg_ar_stall, cfg_aw_stall, cfg_rv_gap, cfg_dmode, cfg_b_delay;

    logic [31:0] mem [2][64][16];
    int n_vec = 0, n_err = 0;
    int cur = 0, ndone = 0, cyc, beats, wbeats, refreshes, last_beat_cyc;
    bit active = 0, ar_done = 0, aw_seen = 0, wlast_done = 0, bresp_done = 0;
    logic [31:0] old_line [16];
    logic [1:0]  oh;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (txn %0d)", tag, got, exp, cur);
        end
    endtask

    // Synchronous data array: 1-cycle read latency, write on dram_we.
    initial begin
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 64; s++)
                for (int i = 0; i < 16; i++) mem[w][s][i] <= 32'(i);
        dram_rdata <= 32'd0;
        forever begin
            @(posedge clk);
            dram_rdata <= mem[dram_rway][dram_rindex][dram_rword];
            if (dram_we[0]) mem[0][dram_windex][dram_wword] <= dram_wdata;
            if (dram_we[1]) mem[1][dram_windex][dram_wword] <= dram_wdata;
        end
    end

    // AXI bridge responder.
    initial begin
        int ar_w, aw_w, tick, bw;
        logic tog;
        ar_w = 0; aw_w = 0; tick = 0; bw = 0; tog = 1'b0;
        rd_ready = 0; rd_valid = 0; rd_data = 0; wr_ready = 0; wr_dready = 0; wr_bresp = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                rd_ready = 0; rd_valid = 0; rd_data = 0; wr_ready = 0; wr_dready = 0; wr_bresp = 0;
                ar_w = 0; aw_w = 0; bw = 0;
            end else begin
                rd_ready = rd_req && ar_w >= cfg_ar_stall;
                ar_w = rd_req ? ar_w + 1 : 0;
                wr_ready = wr_req && aw_w >= cfg_aw_stall;
                aw_w = wr_req ? aw_w + 1 : 0;
                rd_valid = ar_done && beats < 16 && tick == 0;
                tick = tick == 0 ? cfg_rv_gap : tick - 1;
                rd_data = rd_valid ? txn_data[cur][beats] : $urandom;
                tog = ~tog;
                wr_dready = cfg_dmode == 0 ? 1'b1 : cfg_dmode == 1 ? tog : 1'($urandom);
                wr_bresp = wlast_done && !bresp_done && bw >= cfg_b_delay;
                bw = (wlast_done && !bresp_done) ? bw + 1 : 0;
            end
        end
    end

    // Scoreboard: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", 32'(|{refresh, busy, rd_req, rd_addr, wr_req, wr_addr, wr_valid,
                wr_data, wr_last, dram_rway, dram_rindex, dram_rword, dram_we, dram_windex,
                dram_wword, dram_wdata}), 32'd0);
            if (active) cur++;
            active = 0; ar_done = 0; aw_seen = 0; wlast_done = 0; bresp_done = 0;
            beats = 0; wbeats = 0; refreshes = 0;
        end else begin
            if (busy && !active) begin
                chk("txn_queued", 32'(cur < n_pushed), 32'd1);
                active = 1; cyc = 0; beats = 0; wbeats = 0; refreshes = 0; last_beat_cyc = -10;
                ar_done = 0; aw_seen = 0; wlast_done = 0; bresp_done = 0;
                for (int i = 0; i < 16; i++) old_line[i] = mem[txn_way[cur]][txn_idx[cur]][i];
                chk("first_rd_req", 32'(rd_req), 32'(!txn_dirty[cur]));
            end
            if (active) begin
                cyc++;
                oh = txn_way[cur] ? 2'b10 : 2'b01;
                chk("dram_we", 32'(dram_we), (ar_done && rd_valid) ? 32'(oh) : 32'd0);
                if (ar_done && rd_valid) begin
                    chk("dram_windex", 32'(dram_windex), 32'(txn_idx[cur]));
                    chk("dram_wword", 32'(dram_wword), 32'(beats));
                    chk("dram_wdata", dram_wdata, txn_data[cur][beats]);
                    if (beats == 15) last_beat_cyc = cyc;
                    beats++;
                end
                if (rd_req) begin
                    chk("rd_addr", rd_addr, txn_raddr[cur]);
                    chk("rd_len", 32'(rd_len), 32'd15);
                    if (txn_dirty[cur]) chk("rd_before_bresp", 32'(bresp_done), 32'd1);
                    if (rd_ready) ar_done = 1;
                end
                if (wr_req) begin
                    if (!aw_seen) chk("load_cycles", 32'(cyc), 32'd18);
                    aw_seen = 1;
                    chk("wr_addr", wr_addr, txn_waddr[cur]);
                    chk("wr_len", 32'(wr_len), 32'd15);
                end
                if (wr_valid) begin
                    if (wbeats < 16) begin
                        chk("wr_data", wr_data, old_line[wbeats]);
                        chk("wr_last", 32'(wr_last), 32'(wbeats == 15));
                    end else chk("extra_wr_beat", 32'd1, 32'd0);
                    if (wr_dready) begin
                        if (wr_last) wlast_done = 1;
                        wbeats++;
                    end
                end
                if (wr_bresp) bresp_done = 1;
                if (refresh) begin
                    refreshes++;
                    chk("refresh_timing", 32'(cyc), 32'(last_beat_cyc + 1));
                end
                if (!busy) begin
                    chk("rd_beats", 32'(beats), 32'd16);
                    chk("wr_beats", 32'(wbeats), txn_dirty[cur] ? 32'd16 : 32'd0);
                    chk("refresh_count", 32'(refreshes), 32'd1);
                    chk("idle_timing", 32'(cyc), 32'(last_beat_cyc + 3));
                    for (int i = 0; i < 16; i++)
                        chk("line_content", mem[txn_way[cur]][txn_idx[cur]][i], txn_data[cur][i]);
                    ndone++; cur++; active = 0;
                end
            end else begin
                chk("idle_quiet", 32'(|{refresh, rd_req, wr_req, wr_valid, dram_we}), 32'd0);
            end
        end
    end

    task automatic set_cfg(input int ar, input int aw, input int gap, input int dm, input int bd);
        cfg_ar_stall = ar; cfg_aw_stall = aw; cfg_rv_gap = gap; cfg_dmode = dm; cfg_b_delay = bd;
    endtask

    task automatic push_txn(input bit dirty, input bit way, input logic [31:0] ra,
                            input logic [31:0] wa, input bit fixed);
        txn_dirty[n_pushed] = dirty;
        txn_way[n_pushed]   = way;
        txn_raddr[n_pushed] = ra;
        txn_waddr[n_pushed] = wa;
        txn_idx[n_pushed]   = ra[11:6];
        for (int i = 0; i < 16; i++) txn_data[n_pushed][i] = fixed ? 32'hA0 + 32'(i) : $urandom;
        n_pushed++;
        miss = 1; write_back = dirty; lru = way; axi_raddr = ra; axi_waddr = wa;
    endtask

    // Drop miss and wiggle the other request inputs; the latched copies must not follow.
    task automatic scramble();
        miss = 0; write_back = 1'($urandom); lru = 1'($urandom);
        axi_raddr = $urandom; axi_waddr = $urandom;
    endtask

    task automatic wait_done(input int t);
        for (int i = 0; i < 4000 && ndone < t; i++) @(posedge clk);
        if (ndone < t) begin
            $display("FAIL txn_timeout got=%0d exp=%0d", ndone, t);
            $fatal(1);
        end
        #1;
    endtask

    function automatic logic [31:0] line_addr(input logic [5:0] idx);
        logic [31:0] r;
        r = $urandom;
        return {r[31:12], idx, 6'b0};
    endfunction

    initial begin
        logic [31:0] a;
        rst = 1; miss = 0; write_back = 0; lru = 0; axi_raddr = 0; axi_waddr = 0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        push_txn(0, 1, 32'h1FC0_0040, 32'h0, 1);
        @(posedge clk); #1 scramble();
        wait_done(1);
        push_txn(1, 0, 32'h0000_2080, 32'h0000_1080, 0);
        @(posedge clk); #1 scramble();
        wait_done(2);
        set_cfg(0, 0, 2, 1, 2);
        a = line_addr(6'd9);
        push_txn(1, 1, a, line_addr(6'd9), 0);
        @(posedge clk); #1 scramble();
        wait_done(3);
        set_cfg(5, 3, 0, 0, 0);
        push_txn(0, 0, line_addr(6'd12), 32'h0, 0);
        @(posedge clk); #1 scramble();
        wait_done(4);
        set_cfg(0, 0, 0, 0, 0);
        a = line_addr(6'd20);
        push_txn(0, 1, a, 32'h0, 0);
        @(posedge clk); #1 scramble();
        for (int i = 0; i < 200 && beats != 8; i++) begin
            @(negedge clk); #1;
        end
        if (beats != 8) begin
            $display("FAIL reset_point_timeout got=%0d exp=8", beats);
            $fatal(1);
        end
        rst = 1;
        @(negedge clk); #1 rst = 0;
        @(posedge clk); #1;
        push_txn(0, 1, a, 32'h0, 0);
        @(posedge clk); #1 scramble();
        wait_done(5);
        push_txn(1, 0, line_addr(6'd30), line_addr(6'd30), 0);
        @(posedge clk); #1;
        push_txn(0, 1, line_addr(6'd31), 32'h0, 0);
        wait_done(6);
        scramble();
        wait_done(7);
        for (int k = 0; k < 20; k++) begin
            logic [5:0] idx;
            idx = 6'($urandom);
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 4));
            push_txn(1'($urandom), 1'($urandom), line_addr(idx), line_addr(idx), 0);
            @(posedge clk); #1 scramble();
            wait_done(8 + k);
        end
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
